// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore-style control FSM sequencing a shared multicycle RV32I datapath
//   (one ALU, one unified memory port, one register file). Every
//   instruction goes through FETCH, DECODE and a 1-3 state opcode path.
//   It also keeps a retired-instruction counter.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (state FETCH, instret 0)
//   op[6:0]    in   opcode field of the instruction register
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes the current access this cycle
//   PCWrite    out  PCUpdate | (Branch & zero)
//   AdrSrc     out  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  memory write enable
//   IRWrite    out  latch instruction and old PC
//   RegWrite   out  register-file write enable
//   ResultSrc  out  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    out  00 rs2, 01 ImmExt, 10 constant 4
//   ALUOp      out  00 add, 01 subtract, 10 funct-decoded
//   ImmSrc     out  00 I, 01 S, 10 B, 11 J
//   state_o    out  current state encoding
//   instret    out  retired-instruction count (wraps)
//   illegal    out  trap indicator
//
// Build option
//   MC_ILLEGAL_TRAP_EN : unknown opcodes enter an absorbing TRAP state.
//   Undefined (default): unknown opcodes retire as NOPs, illegal tied 0.

module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  state_o,
    output logic [31:0] instret,
    output logic        illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t state;
    state_t next_state;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Retirement = any entry into FETCH from another state (FETCH wait
    // cycles and TRAP self-loops never count).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (next_state == FETCH && state != FETCH) begin
            instret <= instret + 32'd1;
        end
    end

    always_comb begin
        next_state = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      next_state = TRAP;
`else
                    default:      next_state = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                next_state = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                branch     = 1'b1;
                next_state = FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        // State is already FETCH during reset; only the mem_ready-driven
        // enables need suppressing so nothing is written while held.
        if (reset) begin
            IRWrite   = 1'b0;
            pc_update = 1'b0;
            branch    = 1'b0;
            RegWrite  = 1'b0;
        end
    end

    assign PCWrite = pc_update | (branch & zero);

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign state_o = state;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = (state == TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0]  state_o;
    logic [31:0] instret;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .state_o(state_o), .instret(instret), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instruction is a route of states after FETCH; wait states repeat
    // while mem_ready is low; an empty route means back to FETCH.
    int          m_state = 0;
    logic [31:0] m_instret = '0;
    int          route[$];

    always @(posedge clk or posedge reset) begin
        int prev;
        if (reset) begin
            m_state   = 0;
            m_instret = '0;
            route.delete();
        end else begin
            prev = m_state;
            if (m_state == 11) begin
                m_state = 11;
            end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
                m_state = m_state;
            end else if (m_state == 0) begin
                case (op)
                    7'b0000011: route = '{1, 2, 3, 4};
                    7'b0100011: route = '{1, 2, 5};
                    7'b0110011: route = '{1, 6, 7};
                    7'b0010011: route = '{1, 8, 7};
                    7'b1101111: route = '{1, 9, 7};
                    7'b1100011: route = '{1, 10};
`ifdef MC_ILLEGAL_TRAP_EN
                    default:    route = '{1, 11};
`else
                    default:    route = '{1};
`endif
                endcase
                m_state = route.pop_front();
            end else if (route.size() == 0) begin
                m_state = 0;
            end else begin
                m_state = route.pop_front();
            end
            if (m_state == 0 && prev != 0) m_instret = m_instret + 32'd1;
        end
    end

    // Expected control word {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,
    // ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc} from the per-state rules.
    function automatic logic [14:0] exp_ctrl(input int st, input logic [6:0] o,
                                             input logic z, input logic mr, input logic rst);
        logic pcu, br, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, aop, imm;
        pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; aop = 0;
        case (st)
            0:  begin sb = 2; rs = 2; irw = mr; pcu = mr; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; aop = 2; end
            7:  rw = 1;
            8:  begin sa = 2; sb = 1; aop = 2; end
            9:  begin sa = 1; sb = 2; pcu = 1; end
            10: begin sa = 2; aop = 1; br = 1; end
            default: ;
        endcase
        if (rst) begin irw = 0; pcu = 0; br = 0; rw = 0; end
        case (o)
            7'b0100011: imm = 1;
            7'b1100011: imm = 2;
            7'b1101111: imm = 3;
            default:    imm = 0;
        endcase
        return {pcu | (br & z), adr, mw, irw, rw, rs, sa, sb, aop, imm};
    endfunction

    // Single compare process, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", {28'd0, state_o}, m_state);
            check("instret", instret, m_instret);
`ifdef MC_ILLEGAL_TRAP_EN
            check("illegal", {31'd0, illegal}, {31'd0, (m_state == 11)});
`else
            check("illegal", {31'd0, illegal}, 32'd0);
`endif
            check("ctrl", {17'd0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc},
                  {17'd0, exp_ctrl(m_state, op, zero, mem_ready, reset)});
        end
    end

    // ---------------- stimulus ----------------
    // Entered at posedge+1 with the DUT in FETCH; runs one instruction.
    task automatic run_instr(input logic [6:0] o, input logic z, input int fw, input int mwait,
                             output int cyc, output int mwc, output int rwc, output int pwc);
        int fwl, mwl;
        bit left;
        fwl = fw; mwl = mwait; left = 0;
        cyc = 0; mwc = 0; rwc = 0; pwc = 0;
        op = o; zero = z;
        forever begin
            if (state_o == 4'd0 && fwl > 0) begin
                mem_ready = 1'b0; fwl--;
            end else if ((state_o == 4'd3 || state_o == 4'd5) && mwl > 0) begin
                mem_ready = 1'b0; mwl--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (MemWrite) mwc++;
            if (RegWrite) rwc++;
            if (PCWrite)  pwc++;
            @(posedge clk); #1;
            cyc++;
            if (state_o != 4'd0) left = 1;
            if (left && state_o == 4'd0) break;
            if (cyc >= 60) begin
                check("instr_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
    endtask

    int c, mw, rw, pw;

    initial begin
        reset = 1'b1; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_state", {28'd0, state_o}, 32'd0);
        check("rst_irwrite", {31'd0, IRWrite}, 32'd0);
        check("rst_resultsrc", {30'd0, ResultSrc}, 32'd2);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_instr(7'b0000011, 0, 0, 0, c, mw, rw, pw);   // lw
        check("lw_cycles", c, 5);
        check("lw_regwrite", rw, 1);
        check("lw_instret", instret, 1);

        run_instr(7'b0100011, 0, 0, 3, c, mw, rw, pw);   // sw, 3 wait cycles
        check("sw_cycles", c, 7);
        check("sw_memwrite", mw, 4);
        check("sw_regwrite", rw, 0);

        run_instr(7'b0110011, 0, 0, 0, c, mw, rw, pw);   // R
        check("r_cycles", c, 4);
        run_instr(7'b0010011, 0, 2, 0, c, mw, rw, pw);   // I with 2 fetch waits
        check("i_cycles", c, 6);
        check("i_regwrite", rw, 1);

        run_instr(7'b1101111, 0, 0, 0, c, mw, rw, pw);   // jal
        check("jal_cycles", c, 4);
        check("jal_pcwrite", pw, 2);
        check("jal_regwrite", rw, 1);

        run_instr(7'b1100011, 1, 0, 0, c, mw, rw, pw);   // beq taken
        check("beq1_cycles", c, 3);
        check("beq1_pcwrite", pw, 2);
        run_instr(7'b1100011, 0, 0, 0, c, mw, rw, pw);   // beq not taken
        check("beq0_cycles", c, 3);
        check("beq0_pcwrite", pw, 1);
        check("instret_7", instret, 7);

        // Reset in the middle of a load held in MEMREAD.
        op = 7'b0000011; mem_ready = 1'b1;
        c = 0;
        while (state_o != 4'd3 && c < 20) begin
            @(posedge clk); #1; c++;
        end
        check("reach_memread", {28'd0, state_o}, 32'd3);
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", {28'd0, state_o}, 32'd0);
        check("async_rst_instret", instret, 0);
        check("async_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("held_rst_irwrite", {31'd0, IRWrite}, 32'd0);
        check("held_rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        reset = 1'b0;
        run_instr(7'b0110011, 0, 0, 0, c, mw, rw, pw);
        check("post_rst_cycles", c, 4);
        check("post_rst_instret", instret, 1);

`ifdef MC_ILLEGAL_TRAP_EN
        op = 7'b1111111; mem_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("trap_state", {28'd0, state_o}, 32'd11);
        check("trap_illegal", {31'd0, illegal}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("trap_stuck", {28'd0, state_o}, 32'd11);
        check("trap_instret", instret, 1);
        reset = 1'b1; #1;
        check("trap_clear", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
`else
        run_instr(7'b1111111, 0, 0, 0, c, mw, rw, pw);
        check("nop_cycles", c, 2);
        check("nop_instret", instret, 2);
        check("nop_illegal", {31'd0, illegal}, 32'd0);
`endif
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
